// File: rtl/fsic_io_serdes_pkg.sv
// Shared IO-serdes definitions so the TX framer and RX deframer agree on
// link widths, the idle/sync word and the deframer state encoding.
package fsic_io_serdes_pkg;

  localparam int unsigned CLK_RATIO  = 4;
  localparam int unsigned DATA_WIDTH = 32;
  localparam logic [31:0] SYNC_WORD  = 32'h5A5A_A5A5;

  // Deframer state encoding
  typedef logic [1:0] dfr_state_t;
  localparam dfr_state_t DFR_HUNT   = 2'd0;
  localparam dfr_state_t DFR_ALIGN  = 2'd1;
  localparam dfr_state_t DFR_LOCKED = 2'd2;

endpackage

// File: rtl/fsic_io_serdes_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a write while full is accepted
// only when a read happens in the same cycle.
module fsic_io_serdes_sync_fifo #(
  parameter int unsigned pWIDTH = 32,
  parameter int unsigned pDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [pWIDTH-1:0] wr_data,
  input  logic              rd_en,
  output logic [pWIDTH-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;
  localparam int unsigned CW = $clog2(pDEPTH + 1);

  logic [pWIDTH-1:0] mem [pDEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_wr;
  logic              do_rd;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(pDEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(pDEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(pDEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fsic_io_serdes_rx_deframer.sv
// RX deframer: hunts for the sync word in the deserialized nibble stream,
// locks after repeated aligned sync words, and buffers non-idle words.
module fsic_io_serdes_rx_deframer
  import fsic_io_serdes_pkg::*;
#(
  parameter int unsigned            pCLK_RATIO  = CLK_RATIO,
  parameter int unsigned            pDATA_WIDTH = DATA_WIDTH,
  parameter logic [pDATA_WIDTH-1:0] pSYNC_WORD  = pDATA_WIDTH'(SYNC_WORD),
  parameter int unsigned            pLOCK_CNT   = 3,
  parameter int unsigned            pFIFO_DEPTH = 2
) (
  input  logic                   coreclk,
  input  logic                   axis_rst,
  input  logic [pCLK_RATIO-1:0]  rxdata_in,
  input  logic                   rxdata_in_valid,
  input  logic                   align_restart,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   lock,
  output logic                   overflow
);

  localparam int unsigned NIBS = pDATA_WIDTH / pCLK_RATIO;
  localparam int unsigned CW   = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam int unsigned SW   = $clog2(pLOCK_CNT + 1);
  localparam int unsigned RW   = pDATA_WIDTH - pCLK_RATIO;

  // Only the upper part is kept; the oldest nibble falls off on the next shift
  logic [RW-1:0]          sr;
  logic [pDATA_WIDTH-1:0] nxt_word;
  logic [CW-1:0]          nib_cnt;
  logic [CW-1:0]          cnt_nxt;
  logic [SW-1:0]          sync_cnt;
  logic [SW-1:0]          sync_nxt;
  dfr_state_t             state;
  dfr_state_t             state_nxt;
  logic                   boundary;
  logic                   is_sync;
  logic                   push_nxt;
  logic                   push_q;
  logic [pDATA_WIDTH-1:0] push_word;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;

  assign nxt_word = {rxdata_in, sr};
  assign boundary = rxdata_in_valid && (nib_cnt == CW'(NIBS - 1));
  assign is_sync  = (nxt_word == pSYNC_WORD);
  assign m_tvalid = !fifo_empty;
  assign pop      = m_tvalid && m_tready;

  // Next-state, counter and push decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = nib_cnt;
    sync_nxt  = sync_cnt;
    push_nxt  = 1'b0;
    if (rxdata_in_valid) cnt_nxt = boundary ? '0 : nib_cnt + CW'(1);
    if (align_restart) begin
      state_nxt = DFR_HUNT;
      cnt_nxt   = '0;
      sync_nxt  = '0;
    end else if (rxdata_in_valid) begin
      case (state)
        DFR_HUNT: begin
          if (is_sync) begin
            cnt_nxt   = '0;
            sync_nxt  = SW'(1);
            state_nxt = (pLOCK_CNT == 1) ? DFR_LOCKED : DFR_ALIGN;
          end
        end
        DFR_ALIGN: begin
          if (boundary) begin
            if (is_sync) begin
              sync_nxt = sync_cnt + SW'(1);
              if (sync_cnt + SW'(1) == SW'(pLOCK_CNT)) state_nxt = DFR_LOCKED;
            end else begin
              sync_nxt  = '0;
              state_nxt = DFR_HUNT;
            end
          end
        end
        DFR_LOCKED: begin
          if (boundary && !is_sync) push_nxt = 1'b1;
        end
        default: state_nxt = DFR_HUNT;
      endcase
    end
  end

  always_ff @(posedge coreclk) begin
    if (axis_rst) begin
      sr        <= '0;
      nib_cnt   <= '0;
      sync_cnt  <= '0;
      state     <= DFR_HUNT;
      lock      <= 1'b0;
      push_q    <= 1'b0;
      push_word <= '0;
      overflow  <= 1'b0;
    end else begin
      if (rxdata_in_valid) sr <= nxt_word[pDATA_WIDTH-1:pCLK_RATIO];
      nib_cnt  <= cnt_nxt;
      sync_cnt <= sync_nxt;
      state    <= state_nxt;
      lock     <= (state_nxt == DFR_LOCKED);
      push_q   <= push_nxt;
      if (push_nxt) push_word <= nxt_word;
      if (push_q && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  fsic_io_serdes_sync_fifo #(
    .pWIDTH (pDATA_WIDTH),
    .pDEPTH (pFIFO_DEPTH)
  ) u_fifo (
    .clk     (coreclk),
    .rst     (axis_rst),
    .wr_en   (push_q),
    .wr_data (push_word),
    .rd_en   (m_tready),
    .rd_data (m_tdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_fsic_io_serdes_rx_deframer.sv
// Scoreboard bench for the RX deframer: a stream-level reference model
// predicts delivered words, lock and overflow; a monitor checks the DUT.
module tb_fsic_io_serdes_rx_deframer;

  localparam int          NIB      = 8;
  localparam int          DEPTH    = 2;
  localparam int          LOCK_CNT = 3;
  localparam logic [31:0] SYNC     = 32'h5A5A_A5A5;

  logic        coreclk;
  logic        axis_rst;
  logic [3:0]  rxdata_in;
  logic        rxdata_in_valid;
  logic        align_restart;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        lock;
  logic        overflow;

  fsic_io_serdes_rx_deframer dut (
    .coreclk         (coreclk),
    .axis_rst        (axis_rst),
    .rxdata_in       (rxdata_in),
    .rxdata_in_valid (rxdata_in_valid),
    .align_restart   (align_restart),
    .m_tdata         (m_tdata),
    .m_tvalid        (m_tvalid),
    .m_tready        (m_tready),
    .lock            (lock),
    .overflow        (overflow)
  );

  initial begin
    coreclk = 1'b0;
    forever #5 coreclk = ~coreclk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state, in terms of the serial stream
  typedef enum int {M_HUNT, M_ALIGN, M_LOCKED} mode_e;
  mode_e       mode = M_HUNT;
  logic [3:0]  win[$];
  logic [31:0] exp_q[$];
  int          pos = 0;
  int          syncs = 0;
  int          occ = 0;
  bit          pend = 0;
  logic [31:0] pend_word = '0;
  bit          m_lock = 0;
  bit          m_ovf = 0;
  bit          started = 0;

  task automatic model_step();
    bit          popm;
    logic [31:0] w;
    if (axis_rst) begin
      win.delete();
      for (int i = 0; i < NIB; i++) win.push_back(4'h0);
      exp_q.delete();
      mode = M_HUNT; pos = 0; syncs = 0; occ = 0; pend = 0;
      m_lock = 0; m_ovf = 0; started = 1;
      return;
    end
    if (!started) return;
    popm = (occ > 0) && m_tready;
    if (pend) begin
      if (occ < DEPTH || popm) begin
        exp_q.push_back(pend_word);
        occ++;
      end else m_ovf = 1;
    end
    if (popm) occ--;
    pend = 0;
    if (rxdata_in_valid) begin
      win.delete(0);
      win.push_back(rxdata_in);
    end
    w = '0;
    for (int i = 0; i < NIB; i++) w[4*i +: 4] = win[i];
    if (align_restart) begin
      mode = M_HUNT; pos = 0; syncs = 0;
    end else if (rxdata_in_valid) begin
      if (mode == M_HUNT) begin
        if (w == SYNC) begin
          pos = 0; syncs = 1;
          mode = (LOCK_CNT == 1) ? M_LOCKED : M_ALIGN;
        end
      end else begin
        pos++;
        if (pos == NIB) begin
          pos = 0;
          if (mode == M_ALIGN) begin
            if (w == SYNC) begin
              syncs++;
              if (syncs == LOCK_CNT) mode = M_LOCKED;
            end else begin
              syncs = 0; mode = M_HUNT;
            end
          end else if (w != SYNC) begin
            pend = 1; pend_word = w;
          end
        end
      end
    end
    m_lock = (mode == M_LOCKED);
  endtask

  initial forever begin
    @(posedge coreclk);
    model_step();
  end

  // Monitor: compares DUT outputs to the model away from the active edge
  initial forever begin
    @(negedge coreclk);
    if (started) begin
      chk("tvalid", 32'(m_tvalid), 32'(occ > 0));
      chk("lock", 32'(lock), 32'(m_lock));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (m_tvalid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL tdata: got %h expected no word at %0t", m_tdata, $time);
        end else begin
          chk("tdata", m_tdata, exp_q[0]);
          if (m_tready) exp_q.delete(0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input logic [3:0] n, input logic v, input logic r);
    rxdata_in       = n;
    rxdata_in_valid = v;
    align_restart   = r;
    @(posedge coreclk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < NIB; i++) cyc(w[4*i +: 4], 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'h0, 1'b0, 1'b0);
  endtask

  logic [31:0] w;

  initial begin
    axis_rst = 1'b1; m_tready = 1'b1;
    rxdata_in = '0; rxdata_in_valid = 1'b0; align_restart = 1'b0;
    for (int i = 0; i < 2; i++) cyc(4'($urandom), 1'b1, 1'b0);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_lock", 32'(lock), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_tdata", m_tdata, 32'd0);
    axis_rst = 1'b0;
    for (int i = 0; i < 16; i++) cyc(4'($urandom_range(0, 3)), 1'b1, 1'b0);
    chk("nosync_lock", 32'(lock), 32'd0);
    chk("nosync_tvalid", 32'(m_tvalid), 32'd0);

    // Lock, then one data word
    cyc(4'h3, 1'b1, 1'b0);
    send_word(SYNC); send_word(SYNC);
    for (int i = 0; i < NIB - 1; i++) cyc(SYNC[4*i +: 4], 1'b1, 1'b0);
    chk("lock_before_last", 32'(lock), 32'd0);
    cyc(SYNC[31:28], 1'b1, 1'b0);
    chk("lock_after_24", 32'(lock), 32'd1);
    send_word(32'h1234_5678);
    chk("data_latency0", 32'(m_tvalid), 32'd0);
    idle(1);
    chk("data_tvalid", 32'(m_tvalid), 32'd1);
    chk("data_word", m_tdata, 32'h1234_5678);
    idle(1);
    chk("data_one_cycle", 32'(m_tvalid), 32'd0);
    send_word(SYNC);
    idle(3);
    chk("idle_dropped", 32'(m_tvalid), 32'd0);

    // Alignment failure then relock
    cyc(4'h0, 1'b0, 1'b1);
    send_word(SYNC); send_word(SYNC); send_word(32'hDEAD_BEEF);
    chk("alignfail_lock", 32'(lock), 32'd0);
    send_word(SYNC); send_word(SYNC);
    chk("relock_early", 32'(lock), 32'd0);
    send_word(SYNC);
    chk("relock", 32'(lock), 32'd1);

    // Full FIFO with a pop coinciding with the third push
    m_tready = 1'b0;
    send_word(32'h1111_1111); send_word(32'h2222_2222);
    idle(2);
    chk("bp_head", m_tdata, 32'h1111_1111);
    send_word(32'h3333_3333);
    m_tready = 1'b1;
    idle(1);
    chk("coincide_no_ovf", 32'(overflow), 32'd0);
    idle(4);
    chk("coincide_drained", 32'(exp_q.size()), 32'd0);

    // Overflow: third word dropped
    m_tready = 1'b0;
    send_word(32'h1111_1111); send_word(32'h2222_2222); send_word(32'h3333_3333);
    idle(1);
    chk("ovf_set", 32'(overflow), 32'd1);
    m_tready = 1'b1;
    idle(4);
    chk("ovf_drained", 32'(exp_q.size()), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Valid gaps mid-word
    w = 32'hCAFE_F00D;
    for (int i = 0; i < NIB; i++) begin
      cyc(w[4*i +: 4], 1'b1, 1'b0);
      if (i == 2) idle(5);
    end
    idle(1);
    chk("gap_tvalid", 32'(m_tvalid), 32'd1);
    chk("gap_word", m_tdata, 32'hCAFE_F00D);
    idle(2);

    // Restart mid-word
    w = 32'hABCD_1234;
    for (int i = 0; i < 3; i++) cyc(w[4*i +: 4], 1'b1, 1'b0);
    cyc(w[15:12], 1'b1, 1'b1);
    chk("restart_lock", 32'(lock), 32'd0);
    for (int i = 4; i < NIB; i++) cyc(w[4*i +: 4], 1'b1, 1'b0);
    idle(2);
    chk("restart_no_word", 32'(m_tvalid), 32'd0);
    send_word(SYNC); send_word(SYNC); send_word(SYNC);
    chk("restart_relock", 32'(lock), 32'd1);

    // Reset while a word is buffered
    m_tready = 1'b0;
    send_word(32'h0BAD_F00D);
    idle(2);
    chk("pre_rst_tvalid", 32'(m_tvalid), 32'd1);
    axis_rst = 1'b1;
    idle(1);
    chk("midrst_tvalid", 32'(m_tvalid), 32'd0);
    chk("midrst_lock", 32'(lock), 32'd0);
    chk("midrst_tdata", m_tdata, 32'd0);
    axis_rst = 1'b0;

    // Randomized traffic with random alignment, gaps, backpressure, restarts
    for (int i = 0; i < int'($urandom_range(0, 7)); i++) cyc(4'($urandom), 1'b1, 1'b0);
    for (int k = 0; k < 60; k++) begin
      w = (k < 3 || $urandom_range(0, 2) == 0) ? SYNC : $urandom;
      for (int i = 0; i < NIB; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          m_tready = ($urandom_range(0, 3) != 0);
          cyc(4'($urandom), 1'b0, 1'b0);
        end
        m_tready = ($urandom_range(0, 3) != 0);
        cyc(w[4*i +: 4], 1'b1, ($urandom_range(0, 99) == 0));
      end
    end
    m_tready = 1'b1;
    for (int i = 0; i < 20 && (exp_q.size() != 0 || m_tvalid); i++) idle(1);
    chk("final_drained", 32'(exp_q.size()), 32'd0);
    chk("final_tvalid", 32'(m_tvalid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
